// File: rtl/noc_credit_link.sv
// Retiming link between two NoC routers on the clk_noc domain.
// Forward pipe carries flits downstream, reverse pipe carries credits upstream, both
// NUM_PIPELINE stages deep. A credit monitor mirrors the upstream router's credit view
// and raises sticky flags on overflow and spurious-credit violations. It never gates
// the datapath.
module noc_credit_link #(
    parameter int unsigned NUM_PIPELINE      = 2,
    parameter int unsigned FLIT_WIDTH        = 128,
    parameter int unsigned DEST_WIDTH        = 4,
    parameter int unsigned FLIT_BUFFER_DEPTH = 1,
    localparam int unsigned CREDIT_WIDTH     = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [FLIT_WIDTH-1:0]   data_in,
    input  logic [DEST_WIDTH-1:0]   dest_in,
    input  logic                    is_tail_in,
    input  logic                    send_in,
    output logic                    credit_out,
    output logic [FLIT_WIDTH-1:0]   data_out,
    output logic [DEST_WIDTH-1:0]   dest_out,
    output logic                    is_tail_out,
    output logic                    send_out,
    input  logic                    credit_in,
    output logic [CREDIT_WIDTH-1:0] credit_count,
    output logic                    err_overflow,
    output logic                    err_spurious_credit
);

    localparam logic [CREDIT_WIDTH-1:0] MaxCredit = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
    localparam logic [CREDIT_WIDTH-1:0] OneCredit = CREDIT_WIDTH'(1);

    if (NUM_PIPELINE == 0) begin : g_passthru
        assign data_out    = data_in;
        assign dest_out    = dest_in;
        assign is_tail_out = is_tail_in;
        assign send_out    = send_in;
        assign credit_out  = credit_in;
    end else begin : g_pipe
        logic [NUM_PIPELINE-1:0] vld_d, vld_q;
        logic [NUM_PIPELINE-1:0] crd_d, crd_q;
        logic [NUM_PIPELINE-1:0] tail_d, tail_q;
        logic [FLIT_WIDTH-1:0]   data_d [NUM_PIPELINE];
        logic [FLIT_WIDTH-1:0]   data_q [NUM_PIPELINE];
        logic [DEST_WIDTH-1:0]   dest_d [NUM_PIPELINE];
        logic [DEST_WIDTH-1:0]   dest_q [NUM_PIPELINE];

        // Stage inputs: valids shift every cycle, payload advances only behind a valid.
        always_comb begin
            vld_d[0]  = send_in;
            crd_d[0]  = credit_in;
            data_d[0] = send_in ? data_in    : data_q[0];
            dest_d[0] = send_in ? dest_in    : dest_q[0];
            tail_d[0] = send_in ? is_tail_in : tail_q[0];
            for (int k = 1; k < NUM_PIPELINE; k++) begin
                vld_d[k]  = vld_q[k-1];
                crd_d[k]  = crd_q[k-1];
                data_d[k] = vld_q[k-1] ? data_q[k-1] : data_q[k];
                dest_d[k] = vld_q[k-1] ? dest_q[k-1] : dest_q[k];
                tail_d[k] = vld_q[k-1] ? tail_q[k-1] : tail_q[k];
            end
        end

        // Pipe registers; reset discards everything in flight.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q  <= '0;
                crd_q  <= '0;
                tail_q <= '0;
                for (int k = 0; k < NUM_PIPELINE; k++) begin
                    data_q[k] <= '0;
                    dest_q[k] <= '0;
                end
            end else begin
                vld_q  <= vld_d;
                crd_q  <= crd_d;
                tail_q <= tail_d;
                data_q <= data_d;
                dest_q <= dest_d;
            end
        end

        assign send_out    = vld_q[NUM_PIPELINE-1];
        assign credit_out  = crd_q[NUM_PIPELINE-1];
        assign data_out    = data_q[NUM_PIPELINE-1];
        assign dest_out    = dest_q[NUM_PIPELINE-1];
        assign is_tail_out = tail_q[NUM_PIPELINE-1];
    end

    logic [CREDIT_WIDTH-1:0] count_d, count_q;
    logic                    ovf_d, ovf_q;
    logic                    spur_d, spur_q;

    // Monitor next state, seen from the upstream side: a send consumes, a returned credit
    // refunds, both together cancel out.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        spur_d  = spur_q;
        case ({send_in, credit_out})
            2'b10: begin
                if (count_q != '0) count_d = count_q - OneCredit;
                else               ovf_d   = 1'b1;
            end
            2'b01: begin
                if (count_q < MaxCredit) count_d = count_q + OneCredit;
                else                     spur_d  = 1'b1;
            end
            default: ;
        endcase
    end

    // Monitor registers; flags are sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= MaxCredit;
            ovf_q   <= 1'b0;
            spur_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            spur_q  <= spur_d;
        end
    end

    assign credit_count        = count_q;
    assign err_overflow        = ovf_q;
    assign err_spurious_credit = spur_q;

endmodule

// File: doc/noc_credit_link.md
Name: noc_credit_link

Overview:
- Retiming link between a router output port and the neighbouring router's input port.
- Forward path carries data, dest, is_tail and send through NUM_PIPELINE register stages. Reverse path carries credit through the same number of stages.
- A sender-side credit monitor mirrors the upstream router's available-credit view and flags protocol violations.
- Instantiated per inter-router link in the NoC mesh, on the clk_noc domain.

Parameters:
- NUM_PIPELINE, 2, register stages in each direction. 0 means combinational passthrough.
- FLIT_WIDTH, 128, flit payload width.
- DEST_WIDTH, 4, destination field width.
- FLIT_BUFFER_DEPTH, 1, downstream input buffer depth, which sets the initial credit count.
- CREDIT_WIDTH, $clog2(FLIT_BUFFER_DEPTH+1), derived. Not overridable.

Ports:
- clk  input  1  link clock (clk_noc domain).
- rst  input  1  synchronous, active-high reset.
- data_in  input  FLIT_WIDTH  flit from upstream router output.
- dest_in  input  DEST_WIDTH  destination from upstream.
- is_tail_in  input  1  tail marker from upstream.
- send_in  input  1  flit valid from upstream.
- credit_out  output  1  credit returned to upstream router.
- data_out  output  FLIT_WIDTH  flit to downstream router input.
- dest_out  output  DEST_WIDTH  destination to downstream.
- is_tail_out  output  1  tail marker to downstream.
- send_out  output  1  flit valid to downstream.
- credit_in  input  1  credit pulse from downstream router.
- credit_count  output  CREDIT_WIDTH  mirrored upstream available credits.
- err_overflow  output  1  sticky: send issued with zero credits.
- err_spurious_credit  output  1  sticky: credit returned with counter already at FLIT_BUFFER_DEPTH.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; all state is sampled on the rising edge of clk.
- Reset values:
  - send and credit valid bits in every stage are 0, so send_out=0 and credit_out=0.
  - data/dest/is_tail stage registers are 0, so data_out=0, dest_out=0, is_tail_out=0.
  - credit_count=FLIT_BUFFER_DEPTH; both error flags are 0.
- Forward pipe (NUM_PIPELINE>0):
  - Stage k valid[k] <= valid[k-1] every cycle; stage 0 takes send_in.
  - Payload registers (data, dest, is_tail) of stage k load only when valid[k-1] is 1. Otherwise they hold, so payload outputs keep their last value while send_out=0.
  - Latency is exactly NUM_PIPELINE cycles. One flit per cycle is sustained, with no stalls or bubbles inserted.
- Reverse pipe: credit_in delayed by exactly NUM_PIPELINE cycles to credit_out. Pulses are never merged or dropped; back-to-back pulses stay back-to-back.
- NUM_PIPELINE=0: all outputs are combinational copies of their inputs; the monitor still operates.
- Credit monitor, evaluated on the link's upstream-facing signals (send_in, credit_out), registered:
  - send_in=1 and credit_out=0: if count>0, count-1; else set err_overflow and hold count.
  - credit_out=1 and send_in=0: if count<FLIT_BUFFER_DEPTH, count+1; else set err_spurious_credit and hold count.
  - both=1: count unchanged, no error (net zero, including at count=0 and at FLIT_BUFFER_DEPTH).
  - both=0: hold.
- Error flags are sticky until rst. Flits and credits are always forwarded regardless of errors; the monitor never gates the datapath.
- Reset mid-operation: all in-flight flits and credits in the pipes are discarded (valids cleared). Counter returns to FLIT_BUFFER_DEPTH and flags clear in the same cycle.
- No internal state machine beyond the pipes and the counter. Round-trip credit loop = 2*NUM_PIPELINE cycles plus router latency; upstream buffer sizing is the integrator's responsibility.

Test Plan:
1. Reset (NUM_PIPELINE=2, FLIT_BUFFER_DEPTH=4): hold rst 3 cycles -> send_out=0, credit_out=0, data_out=0, credit_count=4, both flags 0.
2. send_in=1 at cycle t with data=128'hA5A5..., dest=4'h3, is_tail=1 -> send_out=1 at t+2 only, with identical payload; credit_count=3 from t+1; data_out holds A5A5... at t+3.
3. credit_in pulses at t and t+1 after two sends -> credit_out=1 at t+2 and t+3; credit_count goes 2→3→4 at t+3 and t+4.
4. Five consecutive sends, no credits, DEPTH=4 -> count 4,3,2,1,0; fifth send sets err_overflow, count stays 0, all five flits appear on send_out.
5. With count=0, send_in and credit_out coincide -> count stays 0, no error. Then an extra credit at count=4 -> err_spurious_credit=1, count stays 4.
6. rst asserted while two flits and one credit are in flight -> none emerge after reset, count=4, flags clear. Repeat scenario 2 with NUM_PIPELINE=0 -> send_out same cycle as send_in.
